// File: rtl/trit_packer.sv
// trit_packer: packs five mod-3 residues per byte, base-3 little-endian, and emits a
// short final byte at the end of each N_COEFF-coefficient polynomial.
// Optional feature macro: TRIT_PACK_CHECK_EN adds a sticky err output and forces
// illegal trits (2'b11) to pack as 0.
module trit_packer #(
  parameter int unsigned N_COEFF = 701
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] in_trit,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_byte,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last
`ifdef TRIT_PACK_CHECK_EN
  ,
  output logic       err
`endif
);

  // Keep the counter at least one bit wide so N_COEFF == 1 still elaborates.
  localparam int unsigned CntW = (N_COEFF > 1) ? $clog2(N_COEFF) : 1;
  localparam logic [CntW-1:0] LastCoef = CntW'(N_COEFF - 1);

  logic [7:0]      acc_q;
  logic [2:0]      pos_q;
  logic [CntW-1:0] coef_cnt_q;

  logic            accept;
  logic            last_coef;
  logic            close_grp;
  logic [7:0]      weight;
  logic [7:0]      trit_val;
  logic [7:0]      acc_next;

  assign in_ready  = !rst && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign last_coef = (coef_cnt_q == LastCoef);
  assign close_grp = accept && ((pos_q == 3'd4) || last_coef);

  // Positional weight and the accumulated partial byte including the incoming trit.
  always_comb begin
    weight = 8'd1;
    unique case (pos_q)
      3'd0:    weight = 8'd1;
      3'd1:    weight = 8'd3;
      3'd2:    weight = 8'd9;
      3'd3:    weight = 8'd27;
      3'd4:    weight = 8'd81;
      default: weight = 8'd1;
    endcase
`ifdef TRIT_PACK_CHECK_EN
    trit_val = (in_trit == 2'b11) ? 8'd0 : {6'd0, in_trit};
`else
    trit_val = {6'd0, in_trit};
`endif
    acc_next = acc_q + trit_val * weight;
  end

  // Accumulator, group position and coefficient counter; frozen unless a trit is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q      <= 8'd0;
      pos_q      <= 3'd0;
      coef_cnt_q <= '0;
    end else if (accept) begin
      coef_cnt_q <= last_coef ? '0 : coef_cnt_q + CntW'(1);
      if (close_grp) begin
        acc_q <= 8'd0;
        pos_q <= 3'd0;
      end else begin
        acc_q <= acc_next;
        pos_q <= pos_q + 3'd1;
      end
    end
  end

  // Output register: a drain clears valid/last, a load on the same edge takes priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_byte  <= 8'd0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
      if (close_grp) begin
        out_byte  <= acc_next;
        out_valid <= 1'b1;
        out_last  <= last_coef;
      end
    end
  end

`ifdef TRIT_PACK_CHECK_EN
  // Sticky flag for an accepted illegal residue; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (accept && (in_trit == 2'b11)) begin
      err <= 1'b1;
    end
  end
`endif

endmodule

// File: doc/trit_packer.md
# trit_packer

Streaming packer that sits directly downstream of the mod-3 reduction stage in the NTRU-HRSS datapath. It consumes one reduced coefficient (trit, 0..2) per handshake and packs groups of five into one byte, base-3 little-endian (byte = t0 + 3·t1 + 9·t2 + 27·t3 + 81·t4). It emits one byte per group, plus a short final byte at the end of each N_COEFF-coefficient polynomial, for the S3 polynomial serialisation path.

## Interface
- N_COEFF, 701, coefficients per polynomial; legal range ≥ 1; the final byte of a polynomial holds N_COEFF mod 5 trits (5 if divisible).
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, synchronous and active-high.
- in_trit  input  2  residue from mod-3 stage; legal values 0, 1, 2.
- in_valid  input  1  in_trit valid.
- in_ready  output  1  packer can accept a trit this cycle.
- out_byte  output  8  packed byte.
- out_valid  output  1  out_byte valid.
- out_ready  input  1  downstream accepts out_byte.
- out_last  output  1  out_byte is the final byte of the current polynomial; qualified by out_valid.
- err  output  1  sticky illegal-trit flag; present only with TRIT_PACK_CHECK_EN.

## Operation
- State: acc[7:0] (partial byte), pos[2:0] (0..4, trit position in group), coef_cnt (0..N_COEFF-1, width $clog2(N_COEFF)), output register {out_byte, out_valid, out_last}.
- Accept: in_valid && in_ready.
- Weight by pos: 1, 3, 9, 27, 81; next = acc + in_trit·weight, computed in 8 bits. Maximum legal value is 242, so no overflow.
- Group closes when an accepted trit has pos == 4 or coef_cnt == N_COEFF-1. On close:
  - out_byte <= next, out_valid <= 1.
  - out_last <= (coef_cnt == N_COEFF-1).
  - acc <= 0, pos <= 0.
- Otherwise: acc <= next, pos <= pos+1.
- coef_cnt increments per accept and wraps to 0 after N_COEFF-1. pos also restarts at 0, so each polynomial begins byte-aligned.
- Output drain: out_valid && out_ready clears out_valid and out_last in the same edge, unless a new byte is loaded on that edge; the load wins.
- in_ready = !rst && (!out_valid || out_ready). Evaluated combinationally, regardless of whether the next trit closes a group.
- out_byte holds its value while out_valid && !out_ready.

## Timing
- Reset values: out_byte = 0, out_valid = 0, out_last = 0, err = 0; internal acc = 0, pos = 0, coef_cnt = 0. in_ready = 0 while rst is high and 1 on the first cycle after.
- Latency: a byte is valid on the cycle after the edge that accepted its closing trit.
- Throughput: 1 trit/cycle sustained while out_ready = 1. There are no bubbles between groups or between polynomials.
- Backpressure: while out_valid && !out_ready, in_ready = 0 and no trit is accepted. All state is frozen.
- Simultaneous drain and load: the old byte transfers and the new byte appears the next cycle, with no gap.
- Reset mid-group or mid-polynomial discards the partial byte and the pending output byte. The next accepted trit is coefficient 0 at pos 0.
- in_trit is ignored when not accepted.

## Configuration
- TRIT_PACK_CHECK_EN defined:
  - err port exists.
  - An accepted in_trit == 2'b11 sets err on the next edge and is packed as 0. err is cleared only by rst.
- TRIT_PACK_CHECK_EN undefined:
  - No err port.
  - 2'b11 is packed arithmetically as value 3, with the sum truncated to 8 bits. Upstream guarantees this does not occur.

## Test plan
- After reset, out_ready = 1, trits 1,2,0,1,2 on consecutive cycles -> one cycle after the 5th accept: out_byte = 0xC4 (196), out_valid = 1 for one cycle, out_last = 0.
- Full polynomial of 701 trits, all value 2, out_ready = 1 -> 141 bytes:
  - bytes 0..139 = 0xF2, out_last = 0;
  - byte 140 = 0x02 with out_last = 1;
  - a following trit 1,1,1,1,1 group yields 0x79 with out_last = 0.
- Byte pending with out_ready = 0 for 4 cycles -> in_ready = 0, out_byte stable, no trits consumed. out_ready = 1 -> byte transfers that edge and in_ready returns to 1 the same cycle.
- Accept trits 2,2,2, assert rst for one cycle, then trits 1,1,1,1,1 -> out_byte = 0x79, with no residue from the discarded partial group.
- Continuous out_ready = 1, 10 trits in 10 consecutive cycles -> 2 bytes, in_ready never deasserted.
- With TRIT_PACK_CHECK_EN: trits 3,1,0,0,0 -> err = 1 the cycle after the first accept and out_byte = 0x03. err stays 1 through further traffic until rst.
